// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter slice:
//   - tx_state_e    : transmitter frame state encoding
//   - PAR_*         : parity-mode constants
//   - CNT_W         : width of the bit-timing counter (covers CLKS_PER_BIT up to 65535)
//   - parity_bit()  : parity helper used when a word is loaded for transmission
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int MAX_DATA_BITS = 9;
    localparam int CNT_W         = 16;

    // Parity over a zero-extended data word; unused upper bits are zero and
    // therefore do not disturb the XOR reduction.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int                       mode);
        logic xor_s;
        logic par_s;
        xor_s = ^data;
        case (mode)
            PAR_EVEN: par_s = xor_s;
            PAR_ODD:  par_s = ~xor_s;
            default:  par_s = 1'b0;
        endcase
        return par_s;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. The counter runs 0..CLKS_PER_BIT-1 while enabled and
// bit_tick is high during the cycle in which the counter holds its final
// value, i.e. the last cycle of each bit period.
// Ports:
//   i_Clock  : clock, rising edge
//   clear    : synchronous clear of counter and tick (highest priority)
//   enable   : count while high; counter held at 0 while low
//   bit_tick : one-cycle pulse on the last cycle of every bit period
//   count    : current position inside the bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic             i_Clock,
    input  logic             clear,
    input  logic             enable,
    output logic             bit_tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] count_r;
    logic             tick_r;

    // Bit-period counter; the tick is registered one cycle ahead so that it
    // coincides with the cycle where the counter sits at CNT_LAST.
    always_ff @(posedge i_Clock) begin
        if (clear) begin
            count_r <= {CNT_W{1'b0}};
            tick_r  <= 1'b0;
        end else if (enable) begin
            if (count_r == CNT_LAST) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            tick_r <= (count_r == CNT_PRE);
        end else begin
            count_r <= {CNT_W{1'b0}};
            tick_r  <= 1'b0;
        end
    end

    assign bit_tick = tick_r;
    assign count    = count_r;

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parameterised UART transmitter with a one-entry holding register so a new
// word can be queued while the previous frame is still on the line.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Ports:
//   i_Clock     : clock, rising edge
//   i_Reset     : synchronous active-high reset
//   i_Tx_DV     : data valid; word accepted when i_Tx_DV && o_Tx_Ready
//   i_Tx_Byte   : data word, captured on acceptance
//   o_Tx_Ready  : holding register empty
//   o_Tx_Active : high from the first start-bit cycle to the last stop-bit cycle
//   o_Tx_Serial : serial line, idle high
//   o_Tx_Done   : one-cycle pulse on the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done
);

    import uart_pkg::*;

    // Illegal parameter combinations stop elaboration.
    if ((CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535)) begin : g_bad_clks_per_bit
        $error("uart_tx_param: CLKS_PER_BIT must be in 2..65535");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if ((PARITY != PAR_NONE) && (PARITY != PAR_ODD) && (PARITY != PAR_EVEN)) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_e            state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_r;
    logic [3:0]           bit_idx_r;
    logic                 serial_r;
    logic                 active_r;
    logic                 done_r;
    logic                 ready_r;
    logic [DATA_BITS-1:0] hold_r;

    logic                 bit_tick_s;
    logic [CNT_W-1:0]     count_s;
    logic                 baud_en_s;
    logic                 accept_s;
    logic                 load_s;
    logic                 last_stop_s;
    logic                 done_next_s;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .i_Clock  (i_Clock),
        .clear    (i_Reset),
        .enable   (baud_en_s),
        .bit_tick (bit_tick_s),
        .count    (count_s)
    );

    // Handshake and frame-sequencing decodes shared by the register blocks.
    always_comb begin
        baud_en_s   = 1'b0;
        accept_s    = 1'b0;
        load_s      = 1'b0;
        last_stop_s = 1'b0;
        done_next_s = 1'b0;

        baud_en_s   = (state_r != ST_IDLE);
        accept_s    = i_Tx_DV & ready_r;
        last_stop_s = (bit_idx_r == LAST_STOP);

        // A held word loads from IDLE at once, or at the end of the final
        // stop bit so the next start bit follows with no idle gap.
        if (ready_r) begin
            load_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            load_s = 1'b1;
        end else if ((state_r == ST_STOP) && bit_tick_s && last_stop_s) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end

        // Done is registered, so it is requested one cycle before the last
        // cycle of the final stop bit.
        if ((state_r == ST_STOP) && last_stop_s && (count_s == CNT_PRE)) begin
            done_next_s = 1'b1;
        end else begin
            done_next_s = 1'b0;
        end
    end

    // Holding register: filled on acceptance, emptied when the frame engine loads it.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            ready_r <= 1'b1;
            hold_r  <= {DATA_BITS{1'b0}};
        end else if (accept_s) begin
            ready_r <= 1'b0;
            hold_r  <= i_Tx_Byte;
        end else if (load_s) begin
            ready_r <= 1'b1;
        end
    end

    // Frame state machine with registered line, active and done outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= {DATA_BITS{1'b0}};
            par_r     <= 1'b0;
            bit_idx_r <= 4'd0;
            serial_r  <= 1'b1;
            active_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= done_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r   <= ST_START;
                        shift_r   <= hold_r;
                        par_r     <= parity_bit(9'(hold_r), PARITY);
                        bit_idx_r <= 4'd0;
                        serial_r  <= 1'b0;
                        active_r  <= 1'b1;
                    end else begin
                        serial_r <= 1'b1;
                        active_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_tick_s) begin
                        state_r   <= ST_DATA;
                        serial_r  <= shift_r[0];
                        shift_r   <= shift_r >> 1;
                        bit_idx_r <= 4'd0;
                    end
                end
                ST_DATA: begin
                    if (bit_tick_s) begin
                        if (bit_idx_r == LAST_DATA) begin
                            bit_idx_r <= 4'd0;
                            if (PARITY != PAR_NONE) begin
                                state_r  <= ST_PARITY;
                                serial_r <= par_r;
                            end else begin
                                state_r  <= ST_STOP;
                                serial_r <= 1'b1;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                            serial_r  <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick_s) begin
                        state_r   <= ST_STOP;
                        serial_r  <= 1'b1;
                        bit_idx_r <= 4'd0;
                    end
                end
                ST_STOP: begin
                    if (bit_tick_s) begin
                        if (last_stop_s) begin
                            bit_idx_r <= 4'd0;
                            if (load_s) begin
                                state_r  <= ST_START;
                                shift_r  <= hold_r;
                                par_r    <= parity_bit(9'(hold_r), PARITY);
                                serial_r <= 1'b0;
                                active_r <= 1'b1;
                            end else begin
                                state_r  <= ST_IDLE;
                                serial_r <= 1'b1;
                                active_r <= 1'b0;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_idx_r <= 4'd0;
                    serial_r  <= 1'b1;
                    active_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Tx_Ready  = ready_r;
    assign o_Tx_Active = active_r;
    assign o_Tx_Serial = serial_r;
    assign o_Tx_Done   = done_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Five transmitter instances with different frame formats share one clock and
// reset. Expected line waveforms come from a frame model that lists the bit
// values of a frame (start, data LSB first, parity from a ones count, stops)
// and holds each for CLKS_PER_BIT cycles.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

    localparam int NDUT = 5;
    localparam int CPB_T  [NDUT] = '{87, 87, 87, 87, 2};
    localparam int DB_T   [NDUT] = '{8, 8, 8, 7, 9};
    localparam int PAR_T  [NDUT] = '{0, 2, 1, 0, 2};
    localparam int STOP_T [NDUT] = '{1, 1, 1, 2, 2};

    logic            clk = 1'b0;
    logic            rst;
    logic [NDUT-1:0] dv;
    logic [8:0]      tx_byte [NDUT];
    logic [NDUT-1:0] ser;
    logic [NDUT-1:0] act;
    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(CPB_T[0]), .DATA_BITS(DB_T[0]), .PARITY(PAR_T[0]), .STOP_BITS(STOP_T[0])) u_dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(tx_byte[0][7:0]),
        .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(done[0]));
    uart_tx_param #(.CLKS_PER_BIT(CPB_T[1]), .DATA_BITS(DB_T[1]), .PARITY(PAR_T[1]), .STOP_BITS(STOP_T[1])) u_dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(tx_byte[1][7:0]),
        .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(done[1]));
    uart_tx_param #(.CLKS_PER_BIT(CPB_T[2]), .DATA_BITS(DB_T[2]), .PARITY(PAR_T[2]), .STOP_BITS(STOP_T[2])) u_dut2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(tx_byte[2][7:0]),
        .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(done[2]));
    uart_tx_param #(.CLKS_PER_BIT(CPB_T[3]), .DATA_BITS(DB_T[3]), .PARITY(PAR_T[3]), .STOP_BITS(STOP_T[3])) u_dut3 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[3]), .i_Tx_Byte(tx_byte[3][6:0]),
        .o_Tx_Ready(rdy[3]), .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]), .o_Tx_Done(done[3]));
    uart_tx_param #(.CLKS_PER_BIT(CPB_T[4]), .DATA_BITS(DB_T[4]), .PARITY(PAR_T[4]), .STOP_BITS(STOP_T[4])) u_dut4 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[4]), .i_Tx_Byte(tx_byte[4]),
        .o_Tx_Ready(rdy[4]), .o_Tx_Active(act[4]), .o_Tx_Serial(ser[4]), .o_Tx_Done(done[4]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Number of line bits in one frame of instance k.
    function automatic int frame_bits(input int k);
        return 1 + DB_T[k] + ((PAR_T[k] != 0) ? 1 : 0) + STOP_T[k];
    endfunction

    function automatic int frame_len(input int k);
        return CPB_T[k] * frame_bits(k);
    endfunction

    // Value of line bit idx in a frame carrying word w on instance k.
    function automatic logic frame_bit(input int k, input logic [8:0] w, input int idx);
        int ones;
        if (idx == 0) return 1'b0;
        if (idx <= DB_T[k]) return w[idx-1];
        if ((PAR_T[k] != 0) && (idx == DB_T[k] + 1)) begin
            ones = 0;
            for (int i = 0; i < DB_T[k]; i++) ones += int'(w[i]);
            if (PAR_T[k] == 2) return ((ones % 2) == 1);
            return ((ones % 2) == 0);
        end
        return 1'b1;
    endfunction

    // Offer one word from idle; leaves the bench one cycle after acceptance.
    task automatic send(input int k, input logic [8:0] w);
        check($sformatf("d%0d ready_before_send", k), rdy[k], 1);
        dv[k]      = 1'b1;
        tx_byte[k] = w;
        @(negedge clk);
        dv[k]      = 1'b0;
        tx_byte[k] = 9'($urandom);
        check($sformatf("d%0d ready_after_accept", k), rdy[k], 0);
        check($sformatf("d%0d line_idle_after_accept", k), ser[k], 1);
    endtask

    // Wait for the start bit, then check every cycle of the frame. Optionally
    // queue push_w at frame cycle push_at and offer a 0x12 word at junk_at.
    task automatic run_frame(input int k, input logic [8:0] w, input int exp_wait,
                             input int push_at, input logic [8:0] push_w, input int junk_at);
        int waited = 0;
        int len    = frame_len(k);
        while ((ser[k] !== 1'b0) && (waited < 5000)) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("d%0d start_wait", k), waited, exp_wait);
        for (int c = 0; c < len; c++) begin
            check($sformatf("d%0d serial c%0d", k, c), ser[k], frame_bit(k, w, c / CPB_T[k]));
            check($sformatf("d%0d done c%0d", k, c), done[k], (c == len - 1));
            check($sformatf("d%0d active c%0d", k, c), act[k], 1);
            check($sformatf("d%0d ready c%0d", k, c), rdy[k], !((push_at >= 0) && (c > push_at)));
            if (c == push_at) begin
                dv[k] = 1'b1;
                tx_byte[k] = push_w;
            end else if (c == junk_at) begin
                dv[k] = 1'b1;
                tx_byte[k] = 9'h012;
            end else if ((c == push_at + 1) || (c == junk_at + 1)) begin
                dv[k] = 1'b0;
                tx_byte[k] = 9'($urandom);
            end
            @(negedge clk);
        end
        dv[k] = 1'b0;
        if (push_at < 0) begin
            check($sformatf("d%0d post_serial", k), ser[k], 1);
            check($sformatf("d%0d post_active", k), act[k], 0);
            check($sformatf("d%0d post_done", k), done[k], 0);
            check($sformatf("d%0d post_ready", k), rdy[k], 1);
        end else if (push_at == len - 1) begin
            check($sformatf("d%0d late_serial", k), ser[k], 1);
            check($sformatf("d%0d late_active", k), act[k], 0);
            check($sformatf("d%0d late_done", k), done[k], 0);
            check($sformatf("d%0d late_ready", k), rdy[k], 0);
        end
    endtask

    initial begin
        logic [8:0] w;
        logic [8:0] pw;
        int         pa;
        int         waited;

        rst = 1'b1;
        dv  = '0;
        for (int k = 0; k < NDUT; k++) tx_byte[k] = 9'h000;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("d%0d reset_serial", k), ser[k], 1);
            check($sformatf("d%0d reset_active", k), act[k], 0);
            check($sformatf("d%0d reset_ready", k), rdy[k], 1);
            check($sformatf("d%0d reset_done", k), done[k], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // 0xAB in 8N1, 8E1 and 8O1
        for (int k = 0; k < 3; k++) begin
            send(k, 9'h0AB);
            run_frame(k, 9'h0AB, 1, -1, 9'h000, -1);
        end

        // Back-to-back 0x55 then 0x0F, plus a 0x12 offer while full
        send(0, 9'h055);
        run_frame(0, 9'h055, 1, 200, 9'h00F, 400);
        run_frame(0, 9'h00F, 0, -1, 9'h000, -1);

        // 7 data bits, two stop bits
        send(3, 9'h07F);
        run_frame(3, 9'h07F, 1, -1, 9'h000, -1);

        // Acceptance on the done cycle, minimum bit period
        send(4, 9'h1A5);
        run_frame(4, 9'h1A5, 1, frame_len(4) - 1, 9'h0C3, -1);
        run_frame(4, 9'h0C3, 1, -1, 9'h000, -1);

        // Reset during data bit 3 with a word held and DV on the reset cycle
        w = 9'h0B6;
        send(0, w);
        waited = 0;
        while ((ser[0] !== 1'b0) && (waited < 5000)) begin
            @(negedge clk);
            waited++;
        end
        check("d0 rst_start_wait", waited, 1);
        for (int c = 0; c < 4 * CPB_T[0] + 20; c++) begin
            dv[0] = (c == 50);
            tx_byte[0] = 9'h05A;
            @(negedge clk);
        end
        dv[0] = 1'b0;
        check("d0 rst_pre_bit3", ser[0], frame_bit(0, w, 4));
        check("d0 rst_pre_ready", rdy[0], 0);
        rst        = 1'b1;
        dv[0]      = 1'b1;
        tx_byte[0] = 9'h03C;
        @(negedge clk);
        rst   = 1'b0;
        dv[0] = 1'b0;
        check("d0 rst_serial", ser[0], 1);
        check("d0 rst_active", act[0], 0);
        check("d0 rst_ready", rdy[0], 1);
        check("d0 rst_done", done[0], 0);
        for (int c = 0; c < 3 * CPB_T[0]; c++) begin
            @(negedge clk);
            check($sformatf("d0 after_rst_serial c%0d", c), ser[0], 1);
            check($sformatf("d0 after_rst_done c%0d", c), done[0], 0);
            check($sformatf("d0 after_rst_active c%0d", c), act[0], 0);
        end

        // Randomised words, gaps and queue positions on every format
        for (int k = 0; k < NDUT; k++) begin
            for (int r = 0; r < 3; r++) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                w = 9'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    pa = $urandom_range(0, frame_len(k) - 2);
                    pw = 9'($urandom);
                    send(k, w);
                    run_frame(k, w, 1, pa, pw, -1);
                    run_frame(k, pw, 0, -1, 9'h000, -1);
                end else begin
                    send(k, w);
                    run_frame(k, w, 1, -1, 9'h000, -1);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
